// File: rtl/canny_pkg.sv
// rtl/canny_pkg.sv - shared codes, constants and FSM state type for the gradient packer
package canny_pkg;

  // Quantised edge direction codes
  localparam logic [1:0] DIR_0   = 2'd0;
  localparam logic [1:0] DIR_45  = 2'd1;
  localparam logic [1:0] DIR_90  = 2'd2;
  localparam logic [1:0] DIR_135 = 2'd3;

  // tan(22.5 deg) and tan(67.5 deg) in Q8 fixed point
  localparam int TAN22_Q8 = 106;
  localparam int TAN67_Q8 = 618;

  // Packed word layout: {dir[1:0], mag[23:0]}
  localparam int MAG_MSB = 23;
  localparam int DIR_LSB = 24;

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

endpackage

// File: rtl/grad_dir_quant.sv
// rtl/grad_dir_quant.sv - two-stage abs/compare/pack pipeline producing {dir, mag}
module grad_dir_quant #(
  parameter int GRAD_WIDTH = 12,
  parameter int DATA_WIDTH = 26
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [GRAD_WIDTH-1:0] grad_x,
  input  logic [GRAD_WIDTH-1:0] grad_y,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_word
);
  import canny_pkg::*;

  // One extra bit so that abs(-2^(GRAD_WIDTH-1)) does not wrap
  localparam int AW = GRAD_WIDTH + 1;
  localparam int CW = MAG_MSB + 1;

  logic [AW-1:0] gx_ext, gy_ext;
  logic [AW-1:0] ax_d, ax_q, ay_d, ay_q;
  logic          sgn_d, sgn_q;
  logic          s1_valid_d, s1_valid_q;
  logic [CW-1:0] ax106_d, ax106_q;
  logic [CW-1:0] ax618_d, ax618_q;
  logic [CW-1:0] ay8_d, ay8_q;
  logic [CW-1:0] mag;
  logic [1:0]    dir;

  // Stage 1 inputs: absolute values, sign relation and the scaled compare operands
  always_comb begin
    gx_ext     = {grad_x[GRAD_WIDTH-1], grad_x};
    gy_ext     = {grad_y[GRAD_WIDTH-1], grad_y};
    ax_d       = gx_ext[AW-1] ? (~gx_ext + AW'(1)) : gx_ext;
    ay_d       = gy_ext[AW-1] ? (~gy_ext + AW'(1)) : gy_ext;
    sgn_d      = grad_x[GRAD_WIDTH-1] ^ grad_y[GRAD_WIDTH-1];
    ax106_d    = CW'(ax_d) * CW'(TAN22_Q8);
    ax618_d    = CW'(ax_d) * CW'(TAN67_Q8);
    ay8_d      = CW'(ay_d) << 8;
    s1_valid_d = in_valid;
  end

  // Stage 1 registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      ax_q       <= '0;
      ay_q       <= '0;
      sgn_q      <= 1'b0;
      ax106_q    <= '0;
      ax618_q    <= '0;
      ay8_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      ax_q       <= ax_d;
      ay_q       <= ay_d;
      sgn_q      <= sgn_d;
      ax106_q    <= ax106_d;
      ax618_q    <= ax618_d;
      ay8_q      <= ay8_d;
    end
  end

  // Stage 2: sector decision and packing; the top registers the result
  always_comb begin
    mag = CW'(ax_q) + CW'(ay_q);
    if (ay8_q <= ax106_q)      dir = DIR_0;
    else if (ay8_q >= ax618_q) dir = DIR_90;
    else if (!sgn_q)           dir = DIR_45;
    else                       dir = DIR_135;
    out_word                  = '0;
    out_word[DIR_LSB +: 2]    = dir;
    out_word[MAG_MSB:0]       = mag;
  end

  assign out_valid = s1_valid_q;

endmodule

// File: rtl/grad_stream_packer.sv
// rtl/grad_stream_packer.sv - frame FSM, raster counters and flush padding around the quantiser
module grad_stream_packer #(
  parameter int WIDTH      = 512,
  parameter int DEPTH      = 636,
  parameter int GRAD_WIDTH = 12,
  parameter int DATA_WIDTH = 26,
  parameter int FLUSH_LEN  = WIDTH + 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  grad_valid,
  input  logic [GRAD_WIDTH-1:0] grad_x,
  input  logic [GRAD_WIDTH-1:0] grad_y,
  output logic                  start,
  output logic                  data_en,
  output logic [DATA_WIDTH-1:0] per_img_Y,
  output logic                  frame_done,
  output logic                  busy,
  output logic                  drop_err
);
  import canny_pkg::*;

  localparam int TOTAL = WIDTH * DEPTH;
  localparam int ACC_W = $clog2(TOTAL + 1);
  localparam int COL_W = $clog2(WIDTH);
  localparam int ROW_W = $clog2(DEPTH);
  localparam int FL_W  = $clog2(FLUSH_LEN + 1);

  state_t                state_d, state_q;
  logic [ACC_W-1:0]      acc_d, acc_q;
  logic [COL_W-1:0]      col_d, col_q;
  logic [ROW_W-1:0]      row_d, row_q;
  logic [FL_W-1:0]       flush_d, flush_q;
  logic                  start_d, start_q;
  logic                  data_en_d, data_en_q;
  logic [DATA_WIDTH-1:0] per_img_Y_d, per_img_Y_q;
  logic                  frame_done_d, frame_done_q;
  logic                  drop_err_d, drop_err_q;
  logic                  accept;
  logic                  last_pix;
  logic                  q_valid;
  logic [DATA_WIDTH-1:0] q_word;

  grad_dir_quant #(
    .GRAD_WIDTH (GRAD_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_quant (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (accept),
    .grad_x    (grad_x),
    .grad_y    (grad_y),
    .out_valid (q_valid),
    .out_word  (q_word)
  );

  // Next-state: accept pixels, issue pipeline words in raster order, then pad and finish
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    col_d        = col_q;
    row_d        = row_q;
    flush_d      = flush_q;
    start_d      = 1'b0;
    data_en_d    = 1'b0;
    per_img_Y_d  = per_img_Y_q;
    frame_done_d = 1'b0;
    accept       = grad_valid && (state_q == STREAM) && (acc_q < ACC_W'(TOTAL));
    last_pix     = (col_q == COL_W'(WIDTH - 1)) && (row_q == ROW_W'(DEPTH - 1));
    drop_err_d   = (grad_valid && !accept) || (frame_start && (state_q != IDLE));

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d = STREAM;
          acc_d   = '0;
          col_d   = '0;
          row_d   = '0;
          flush_d = '0;
        end
      end
      STREAM: begin
        if (accept) acc_d = acc_q + ACC_W'(1);
        if (q_valid) begin
          start_d     = 1'b1;
          data_en_d   = 1'b1;
          per_img_Y_d = q_word;
          if (last_pix) begin
            state_d = FLUSH;
            col_d   = '0;
            row_d   = '0;
          end else if (col_q == COL_W'(WIDTH - 1)) begin
            col_d = '0;
            row_d = row_q + ROW_W'(1);
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      FLUSH: begin
        start_d     = 1'b1;
        per_img_Y_d = '0;
        if (flush_q == FL_W'(FLUSH_LEN - 1)) begin
          state_d = DONE;
          flush_d = '0;
        end else begin
          flush_d = flush_q + FL_W'(1);
        end
      end
      DONE: begin
        frame_done_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered outputs; reset abandons any frame in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      col_q        <= '0;
      row_q        <= '0;
      flush_q      <= '0;
      start_q      <= 1'b0;
      data_en_q    <= 1'b0;
      per_img_Y_q  <= '0;
      frame_done_q <= 1'b0;
      drop_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      col_q        <= col_d;
      row_q        <= row_d;
      flush_q      <= flush_d;
      start_q      <= start_d;
      data_en_q    <= data_en_d;
      per_img_Y_q  <= per_img_Y_d;
      frame_done_q <= frame_done_d;
      drop_err_q   <= drop_err_d;
    end
  end

  assign start      = start_q;
  assign data_en    = data_en_q;
  assign per_img_Y  = per_img_Y_q;
  assign frame_done = frame_done_q;
  assign drop_err   = drop_err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_grad_stream_packer.sv
// tb/tb_grad_stream_packer.sv - directed self-checking bench for grad_stream_packer
module tb_grad_stream_packer;
  localparam int W  = 4;
  localparam int D  = 3;
  localparam int FL = 6;
  localparam int GW = 12;
  localparam int DW = 26;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_start;
  logic          grad_valid;
  logic [GW-1:0] grad_x;
  logic [GW-1:0] grad_y;
  logic          start;
  logic          data_en;
  logic [DW-1:0] per_img_Y;
  logic          frame_done;
  logic          busy;
  logic          drop_err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // {start, data_en, frame_done, busy, drop_err, per_img_Y}
  logic [30:0] obs_log[$];
  logic [30:0] exp_log[$];
  int          in_tick[12];
  logic [GW-1:0] vx[12];
  logic [GW-1:0] vy[12];
  logic [DW-1:0] vw[12];

  always #5 clk = ~clk;

  grad_stream_packer #(
    .WIDTH      (W),
    .DEPTH      (D),
    .GRAD_WIDTH (GW),
    .DATA_WIDTH (DW),
    .FLUSH_LEN  (FL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .grad_valid  (grad_valid),
    .grad_x      (grad_x),
    .grad_y      (grad_y),
    .start       (start),
    .data_en     (data_en),
    .per_img_Y   (per_img_Y),
    .frame_done  (frame_done),
    .busy        (busy),
    .drop_err    (drop_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    obs_log.push_back({start, data_en, frame_done, busy, drop_err, per_img_Y});
  endtask

  // Drives one 12-pixel frame and builds the expected per-cycle output schedule
  task automatic run_frame(input bit gaps, input bit inj_mid, input bit inj_done);
    int            mid_idx;
    int            last;
    logic [DW-1:0] y;
    logic          de;
    logic          fl;
    obs_log.delete();
    exp_log.delete();
    mid_idx     = -1;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      grad_valid = 1'b1;
      grad_x     = vx[i];
      grad_y     = vy[i];
      in_tick[i] = obs_log.size();
      if (inj_mid && i == 5) begin
        frame_start = 1'b1;
        mid_idx     = obs_log.size();
      end
      tick();
      frame_start = 1'b0;
      if (gaps && i < 11) begin
        grad_valid = 1'b0;
        tick();
      end
    end
    grad_valid = 1'b0;
    last = in_tick[11] + 1;
    while (obs_log.size() < last + 9) begin
      if (inj_done && obs_log.size() == last + 7) frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
    end
    y = '0;
    for (int j = 0; j < last + 9; j++) begin
      de = 1'b0;
      for (int i = 0; i < 12; i++) begin
        if (j == in_tick[i] + 1) begin
          de = 1'b1;
          y  = vw[i];
        end
      end
      fl = (j >= last + 1) && (j <= last + FL);
      if (fl) y = '0;
      exp_log.push_back({de | fl, de, 1'(j == last + 7), 1'(j <= last + 6),
                         1'((j == mid_idx) || (inj_done && j == last + 7)), y});
    end
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    frame_start = 1'b0;
    grad_valid  = 1'b0;
    grad_x      = '0;
    grad_y      = '0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if ({start, data_en, frame_done, busy, drop_err} !== 5'b0)
      $display("FAIL reset_flags got %b exp 00000", {start, data_en, frame_done, busy, drop_err});
    else pass_cnt++;
    total_cnt++;
    if (per_img_Y !== '0) $display("FAIL reset_data got %h exp 0", per_img_Y);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_pixel_values();
    int k;
    run_frame(1'b0, 1'b0, 1'b0);
    k = 0;
    for (int j = 0; j < obs_log.size(); j++) begin
      if (obs_log[j][29]) begin
        if (k < 12) begin
          total_cnt++;
          if (obs_log[j][DW-1:0] !== vw[k])
            $display("FAIL pixel%0d got %h exp %h", k, obs_log[j][DW-1:0], vw[k]);
          else pass_cnt++;
        end
        k++;
      end
    end
    total_cnt++;
    if (k !== 12) $display("FAIL pixel_count got %0d exp 12", k);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    run_frame(1'b0, 1'b0, 1'b0);
    for (int j = 0; j < exp_log.size(); j++) begin
      total_cnt++;
      if (obs_log[j] !== exp_log[j])
        $display("FAIL b2b idx%0d got %h exp %h", j, obs_log[j], exp_log[j]);
      else pass_cnt++;
    end
  endtask

  task automatic test_gaps();
    int n;
    run_frame(1'b1, 1'b0, 1'b0);
    n = 0;
    for (int j = 0; j < exp_log.size(); j++) begin
      if (obs_log[j][29]) n++;
      total_cnt++;
      if (obs_log[j] !== exp_log[j])
        $display("FAIL gaps idx%0d got %h exp %h", j, obs_log[j], exp_log[j]);
      else pass_cnt++;
    end
    total_cnt++;
    if (n !== 12) $display("FAIL gaps_count got %0d exp 12", n);
    else pass_cnt++;
  endtask

  task automatic test_drop_err();
    grad_valid = 1'b1;
    grad_x     = 12'd9;
    grad_y     = 12'd9;
    @(posedge clk);
    #1;
    total_cnt++;
    if ({drop_err, start, data_en, busy} !== 4'b1000)
      $display("FAIL idle_drop got %b exp 1000", {drop_err, start, data_en, busy});
    else pass_cnt++;
    grad_valid = 1'b0;
    @(posedge clk);
    #1;
    total_cnt++;
    if ({drop_err, start} !== 2'b00) $display("FAIL idle_quiet got %b exp 00", {drop_err, start});
    else pass_cnt++;
    run_frame(1'b0, 1'b1, 1'b1);
    for (int j = 0; j < exp_log.size(); j++) begin
      total_cnt++;
      if (obs_log[j] !== exp_log[j])
        $display("FAIL drop idx%0d got %h exp %h", j, obs_log[j], exp_log[j]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_midframe();
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      grad_valid = 1'b1;
      grad_x     = vx[i];
      grad_y     = vy[i];
      @(posedge clk);
      #1;
    end
    total_cnt++;
    if ({start, data_en, busy} !== 3'b111)
      $display("FAIL pre_reset got %b exp 111", {start, data_en, busy});
    else pass_cnt++;
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({start, data_en, frame_done, busy, drop_err, per_img_Y} !== 31'b0)
      $display("FAIL async_reset got %h exp 0", {start, data_en, frame_done, busy, drop_err, per_img_Y});
    else pass_cnt++;
    grad_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_frame(1'b0, 1'b0, 1'b0);
    for (int j = 0; j < exp_log.size(); j++) begin
      total_cnt++;
      if (obs_log[j] !== exp_log[j])
        $display("FAIL after_reset idx%0d got %h exp %h", j, obs_log[j], exp_log[j]);
      else pass_cnt++;
    end
  endtask

  initial begin
    vx[0]  = 12'd10;   vy[0]  = 12'd0;    vw[0]  = {2'd0, 24'd10};
    vx[1]  = 12'd0;    vy[1]  = -12'sd7;  vw[1]  = {2'd2, 24'd7};
    vx[2]  = 12'd5;    vy[2]  = 12'd5;    vw[2]  = {2'd1, 24'd10};
    vx[3]  = 12'd5;    vy[3]  = -12'sd5;  vw[3]  = {2'd3, 24'd10};
    vx[4]  = 12'h800;  vy[4]  = 12'd0;    vw[4]  = {2'd0, 24'd2048};
    vx[5]  = 12'd100;  vy[5]  = 12'd41;   vw[5]  = {2'd0, 24'd141};
    vx[6]  = 12'd100;  vy[6]  = 12'd42;   vw[6]  = {2'd1, 24'd142};
    vx[7]  = 12'd10;   vy[7]  = 12'd25;   vw[7]  = {2'd2, 24'd35};
    vx[8]  = 12'd0;    vy[8]  = 12'd0;    vw[8]  = {2'd0, 24'd0};
    vx[9]  = -12'sd50; vy[9]  = 12'd20;   vw[9]  = {2'd0, 24'd70};
    vx[10] = -12'sd50; vy[10] = 12'd30;   vw[10] = {2'd3, 24'd80};
    vx[11] = 12'd2047; vy[11] = 12'h800;  vw[11] = {2'd3, 24'd4095};

    test_reset();
    test_pixel_values();
    test_back_to_back();
    test_gaps();
    test_drop_err();
    test_reset_midframe();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
